// File: rtl/pulse_measure_if.sv
// Edge-strobe inputs and measurement results of pulse_measure bundled as one port.
interface pulse_measure_if #(
    parameter int unsigned WIDTH = 24
);
    logic             pos;
    logic             neg;
    logic [WIDTH-1:0] highCycles;
    logic [WIDTH-1:0] periodCycles;
    logic             valid;
    logic             locked;
    logic             timeout;
    logic             glitch;

    modport master (
        output pos, neg,
        input  highCycles, periodCycles, valid, locked, timeout, glitch
    );

    modport slave (
        input  pos, neg,
        output highCycles, periodCycles, valid, locked, timeout, glitch
    );
endinterface

// File: rtl/pulse_measure.sv
// Measures high width and period (in clock cycles) of a signal from its edge strobes,
// publishing one result per period along with lock, timeout and glitch status.
module pulse_measure #(
    parameter int unsigned WIDTH          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    pulse_measure_if.slave  pm_if
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_high_latch;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             r_glitch;

    logic [1:0]       w_state_d;
    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] w_high_latch_d;
    logic [WIDTH-1:0] w_high_d;
    logic [WIDTH-1:0] w_period_d;
    logic             w_valid_d;
    logic             w_locked_d;
    logic             w_timeout_d;
    logic             w_glitch_d;
    logic             w_timeout_hit;

    // A pos in the same cycle always wins over the timeout, so period == TIMEOUT is legal.
    assign w_timeout_hit = (r_state != IDLE) && (r_cnt == TIMEOUT_VAL) && !pm_if.pos;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_high_latch_d = r_high_latch;
        w_high_d       = r_high;
        w_period_d     = r_period;
        w_valid_d      = 1'b0;
        w_locked_d     = r_locked;
        w_timeout_d    = 1'b0;
        w_glitch_d     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (pm_if.pos) begin
                    w_state_d = HIGH;
                    w_cnt_d   = CNT_ONE;
                end else begin
                    w_cnt_d = '0;
                end
            end
            HIGH: begin
                if (pm_if.pos) begin
                    w_cnt_d    = CNT_ONE;
                    w_glitch_d = 1'b1;
                    w_locked_d = 1'b0;
                end else if (w_timeout_hit) begin
                    w_state_d   = IDLE;
                    w_cnt_d     = '0;
                    w_locked_d  = 1'b0;
                    w_timeout_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                    if (pm_if.neg) begin
                        w_high_latch_d = r_cnt;
                        w_state_d      = LOW;
                    end
                end
            end
            LOW: begin
                if (pm_if.pos) begin
                    w_period_d = r_cnt;
                    w_high_d   = r_high_latch;
                    w_valid_d  = 1'b1;
                    w_locked_d = 1'b1;
                    w_cnt_d    = CNT_ONE;
                    w_state_d  = HIGH;
                end else if (w_timeout_hit) begin
                    w_state_d   = IDLE;
                    w_cnt_d     = '0;
                    w_locked_d  = 1'b0;
                    w_timeout_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_high_latch <= '0;
            r_high       <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
            r_glitch     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_high_latch <= w_high_latch_d;
            r_high       <= w_high_d;
            r_period     <= w_period_d;
            r_valid      <= w_valid_d;
            r_locked     <= w_locked_d;
            r_timeout    <= w_timeout_d;
            r_glitch     <= w_glitch_d;
        end
    end

    assign pm_if.highCycles   = r_high;
    assign pm_if.periodCycles = r_period;
    assign pm_if.valid        = r_valid;
    assign pm_if.locked       = r_locked;
    assign pm_if.timeout      = r_timeout;
    assign pm_if.glitch       = r_glitch;
endmodule

// File: tb/tb_pulse_measure.sv
// Scenario bench for pulse_measure (WIDTH=8, TIMEOUT_CYCLES=20) with a valid-result scoreboard.
module tb_pulse_measure;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 20;

    typedef struct {
        int         cyc;
        logic [7:0] hi;
        logic [7:0] per;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n_valid = 0;
    int   n_timeout = 0;
    int   n_glitch = 0;
    bit   prev_pulse = 1'b0;
    exp_t sb[$];
    exp_t e;

    pulse_measure_if #(.WIDTH(W)) bus ();

    pulse_measure #(
        .WIDTH         (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pm_if(bus)
    );

    always #5 clk = ~clk;

    // Scoreboard and pulse-property monitor.
    always @(posedge clk) begin
        int w;
        #1;
        if (bus.valid === 1'b1) begin
            n_valid++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid cyc=%0d hi=%0d per=%0d", cyc, bus.highCycles,
                         bus.periodCycles);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || bus.highCycles !== e.hi || bus.periodCycles !== e.per) begin
                    fails++;
                    $display("FAIL sb_valid got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                             cyc, bus.highCycles, bus.periodCycles, e.cyc, e.hi, e.per);
                end
            end
        end
        if (bus.timeout === 1'b1) n_timeout++;
        if (bus.glitch === 1'b1) n_glitch++;
        w = int'(bus.valid) + int'(bus.timeout) + int'(bus.glitch);
        if (w != 0) begin
            tests++;
            if (w > 1 || prev_pulse) begin
                fails++;
                $display("FAIL pulse_excl cyc=%0d got v/t/g=%b%b%b prev=%0d want single isolated",
                         cyc, bus.valid, bus.timeout, bus.glitch, prev_pulse);
            end
        end
        prev_pulse = (w != 0);
    end

    task automatic step(input logic p, input logic n);
        bus.pos = p;
        bus.neg = n;
        @(posedge clk);
        cyc++;
        #2;
        bus.pos = 1'b0;
        bus.neg = 1'b0;
    endtask

    task automatic strobe(input int t, input logic p, input logic n);
        while (cyc < t) step(1'b0, 1'b0);
        step(p, n);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.pos = 1'b0;
        bus.neg = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.pos = 1'b1;
        bus.neg = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if ({bus.valid, bus.locked, bus.timeout, bus.glitch, bus.highCycles, bus.periodCycles}
            !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b l=%b t=%b g=%b hi=%0d per=%0d want all 0",
                     bus.valid, bus.locked, bus.timeout, bus.glitch, bus.highCycles,
                     bus.periodCycles);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        strobe(2, 1'b0, 1'b1);
        strobe(5, 1'b1, 1'b0);
        strobe(8, 1'b0, 1'b1);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL basic_prelock got %b want 0", bus.locked);
        end
        sb.push_back('{16, 8'd3, 8'd10});
        strobe(15, 1'b1, 1'b0);
        tests++;
        if (bus.valid !== 1'b1 || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL basic_at16 got v=%b l=%b want v=1 l=1", bus.valid, bus.locked);
        end
        run_to(20);
        tests++;
        if (sb.size() != 0 || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL basic_end got pending=%0d l=%b want 0 1", sb.size(), bus.locked);
        end
    endtask

    task automatic test_steady();
        int v0, t0, g0;
        do_reset();
        v0 = n_valid;
        t0 = n_timeout;
        g0 = n_glitch;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) sb.push_back('{6 + 6 * k, 8'd2, 8'd6});
            strobe(5 + 6 * k, 1'b1, 1'b0);
            strobe(7 + 6 * k, 1'b0, 1'b1);
        end
        run_to(58);
        tests++;
        if (n_valid - v0 != 8 || n_timeout != t0 || n_glitch != g0 || sb.size() != 0) begin
            fails++;
            $display("FAIL steady got valids=%0d to=%0d gl=%0d pending=%0d want 8 0 0 0",
                     n_valid - v0, n_timeout - t0, n_glitch - g0, sb.size());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        sb.push_back('{12, 8'd2, 8'd6});
        strobe(5, 1'b1, 1'b0);
        strobe(7, 1'b0, 1'b1);
        strobe(11, 1'b1, 1'b0);
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL glitch_lock got %b want 1", bus.locked);
        end
        strobe(15, 1'b1, 1'b0);
        tests++;
        if (bus.glitch !== 1'b1 || bus.locked !== 1'b0 || bus.valid !== 1'b0 ||
            bus.highCycles !== 8'd2 || bus.periodCycles !== 8'd6) begin
            fails++;
            $display("FAIL glitch_pulse got g=%b l=%b v=%b hi=%0d per=%0d want 1 0 0 2 6",
                     bus.glitch, bus.locked, bus.valid, bus.highCycles, bus.periodCycles);
        end
        strobe(17, 1'b0, 1'b1);
        sb.push_back('{24, 8'd2, 8'd8});
        strobe(23, 1'b1, 1'b0);
        tests++;
        if (bus.valid !== 1'b1 || bus.locked !== 1'b1 || sb.size() != 0) begin
            fails++;
            $display("FAIL glitch_recover got v=%b l=%b pending=%0d want 1 1 0",
                     bus.valid, bus.locked, sb.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) sb.push_back('{5 + 6 * k, 8'd2, 8'd6});
            strobe(4 + 6 * k, 1'b1, 1'b0);
            if (k < 6) strobe(6 + 6 * k, 1'b0, 1'b1);
        end
        run_to(60);
        tests++;
        if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early got t=%b l=%b want 0 1", bus.timeout, bus.locked);
        end
        step(1'b0, 1'b0);
        tests++;
        if (bus.timeout !== 1'b1 || bus.locked !== 1'b0 || bus.highCycles !== 8'd2 ||
            bus.periodCycles !== 8'd6) begin
            fails++;
            $display("FAIL timeout_at61 got t=%b l=%b hi=%0d per=%0d want 1 0 2 6",
                     bus.timeout, bus.locked, bus.highCycles, bus.periodCycles);
        end
        strobe(65, 1'b1, 1'b0);
        tests++;
        if (bus.valid !== 1'b0 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL timeout_restart got v=%b l=%b want 0 0", bus.valid, bus.locked);
        end
        strobe(67, 1'b0, 1'b1);
        sb.push_back('{71, 8'd2, 8'd5});
        strobe(70, 1'b1, 1'b0);
        tests++;
        if (bus.valid !== 1'b1 || bus.locked !== 1'b1 || sb.size() != 0) begin
            fails++;
            $display("FAIL timeout_relock got v=%b l=%b pending=%0d want 1 1 0",
                     bus.valid, bus.locked, sb.size());
        end
    endtask

    task automatic test_boundary();
        int t0;
        do_reset();
        sb.push_back('{26, 8'd2, 8'd20});
        strobe(5, 1'b1, 1'b0);
        strobe(7, 1'b0, 1'b1);
        t0 = n_timeout;
        strobe(25, 1'b1, 1'b0);
        tests++;
        if (bus.valid !== 1'b1 || bus.periodCycles !== 8'd20 || n_timeout != t0) begin
            fails++;
            $display("FAIL boundary_valid got v=%b per=%0d to=%0d want 1 20 0",
                     bus.valid, bus.periodCycles, n_timeout - t0);
        end
        strobe(27, 1'b0, 1'b1);
        run_to(45);
        tests++;
        if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL boundary_low_early got t=%b l=%b want 0 1", bus.timeout, bus.locked);
        end
        step(1'b0, 1'b0);
        tests++;
        if (bus.timeout !== 1'b1 || bus.locked !== 1'b0 || bus.highCycles !== 8'd2 ||
            bus.periodCycles !== 8'd20) begin
            fails++;
            $display("FAIL boundary_low_to got t=%b l=%b hi=%0d per=%0d want 1 0 2 20",
                     bus.timeout, bus.locked, bus.highCycles, bus.periodCycles);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        do_reset();
        sb.push_back('{16, 8'd3, 8'd10});
        strobe(5, 1'b1, 1'b0);
        strobe(8, 1'b0, 1'b1);
        strobe(15, 1'b1, 1'b0);
        strobe(18, 1'b0, 1'b1);
        run_to(20);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        tests++;
        if ({bus.valid, bus.locked, bus.timeout, bus.glitch, bus.highCycles, bus.periodCycles}
            !== '0) begin
            fails++;
            $display("FAIL reset_mid got v=%b l=%b t=%b g=%b hi=%0d per=%0d want all 0",
                     bus.valid, bus.locked, bus.timeout, bus.glitch, bus.highCycles,
                     bus.periodCycles);
        end
        v0 = n_valid;
        strobe(25, 1'b1, 1'b0);
        run_to(40);
        tests++;
        if (n_valid != v0 || sb.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_novalid got valids=%0d pending=%0d want 0 0",
                     n_valid - v0, sb.size());
        end
    endtask

    initial begin
        bus.pos = 1'b0;
        bus.neg = 1'b0;
        test_reset();
        test_basic();
        test_steady();
        test_glitch();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
